// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one data BRAM between the core (port 0) and a host/debug loader (port 1).
// Port 0 has fixed priority; port 1 wins after STARVE_LIMIT lost cycles; either port can lock ownership.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_BITS    = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_BITS-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_BITS-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  lock;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t [1:0] req;
  state_t     state, next_state;
  logic [1:0] gnt;
  logic       sel;
  logic [3:0] starve_cnt;
  logic [1:0] vld_pipe;  // [0] = read issued this cycle, [1] = read data returning
  logic       rsp_port;

  assign req[0] = {req0_valid, req0_we, req0_lock, req0_addr, req0_wdata};
  assign req[1] = {req1_valid, req1_we, req1_lock, req1_addr, req1_wdata};

  // Grant is gated by reset so no handshake can complete while held in reset.
  always_comb begin
    gnt        = 2'b00;
    next_state = state;
    if (!reset) begin
      case (state)
        LOCK0:   gnt[0] = req[0].valid;
        LOCK1:   gnt[1] = req[1].valid;
        default: begin
          gnt[1] = req[1].valid && (starve_cnt == LIMIT || !req[0].valid);
          gnt[0] = req[0].valid && !gnt[1];
        end
      endcase
    end
    sel = gnt[1];
    if (|gnt)
      next_state = req[sel].lock ? (sel ? LOCK1 : LOCK0) : IDLE;
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign mem_en    = |gnt;
  assign mem_we    = mem_en & req[sel].we;
  assign mem_addr  = mem_en ? req[sel].addr  : '0;
  assign mem_wdata = mem_en ? req[sel].wdata : '0;

  assign vld_pipe[0] = mem_en & ~req[sel].we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      vld_pipe[1] <= 1'b0;
      rsp_port    <= 1'b0;
    end else begin
      state       <= next_state;
      vld_pipe[1] <= vld_pipe[0];
      rsp_port    <= sel;
      if (gnt[1])
        starve_cnt <= '0;
      else if (req[1].valid && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign rsp0_valid = vld_pipe[1] & ~rsp_port;
  assign rsp1_valid = vld_pipe[1] &  rsp_port;
  assign rsp0_data  = rsp0_valid ? mem_rdata : '0;
  assign rsp1_data  = rsp1_valid ? mem_rdata : '0;

endmodule
